wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Register file with write-back bypass and a per-register in-flight scoreboard.
// Stall guards operand hazards and in-flight counter saturation; ScoreErr flags scoreboard underflow.
module wb_regfile #(
    parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        WBWrite,
    input  logic [4:0]  WBAddr,
    input  logic [31:0] WBData,
    input  logic [4:0]  ReadAddrA,
    input  logic [4:0]  ReadAddrB,
    input  logic        UseA,
    input  logic        UseB,
    input  logic        IssueValid,
    input  logic [4:0]  IssueDest,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic        Stall,
    output logic        ScoreErr
);

    // Entry 0 is reset to zero and never written, so it reads as 0 without a mux.
    logic [31:0] regs [32];
    logic [1:0]  cnt  [32];

    logic        wb_en;
    logic        byp_a;
    logic        byp_b;
    logic        haz_a;
    logic        haz_b;
    logic        full;
    logic        issue_go;
    logic        underflow;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    logic        score_err;

    always_comb begin
        wb_en = WBWrite && (WBAddr != 5'd0);
        byp_a = wb_en && (WBAddr == ReadAddrA);
        byp_b = wb_en && (WBAddr == ReadAddrB);

        // A bypass only clears the hazard when this write-back is the last one pending.
        haz_a = UseA && (cnt[ReadAddrA] != 2'd0) && !(byp_a && (cnt[ReadAddrA] == 2'd1));
        haz_b = UseB && (cnt[ReadAddrB] != 2'd0) && !(byp_b && (cnt[ReadAddrB] == 2'd1));
        full  = (IssueDest != 5'd0) && (cnt[IssueDest] == 2'd3);
        Stall = haz_a || haz_b || full;

        issue_go  = IssueValid && !Stall && (IssueDest != 5'd0);
        inc_vec   = issue_go ? (32'd1 << IssueDest) : 32'd0;
        dec_vec   = wb_en ? (32'd1 << WBAddr) : 32'd0;
        underflow = wb_en && !inc_vec[WBAddr] && (cnt[WBAddr] == 2'd0);

        DataA = byp_a ? WBData : regs[ReadAddrA];
        DataB = byp_b ? WBData : regs[ReadAddrB];
    end

    // NOTE: the array is reset on purpose (its reset contents are visible on the read ports),
    // so it maps to flops with async clear rather than a RAM macro.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 0) ? 32'd0 : REG_RESET;
                cnt[i]  <= 2'd0;
            end
            score_err <= 1'b0;
        end else begin
            if (wb_en) begin
                regs[WBAddr] <= WBData;
            end
            // Simultaneous issue and write-back on one register cancel; decrement clamps at 0.
            for (int i = 0; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != 2'd0)) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
            if (underflow) begin
                score_err <= 1'b1;
            end
        end
    end

    assign ScoreErr = score_err;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed vector table, async-reset sequence, then
// randomized traffic checked against a behavioural scoreboard model.
module tb_wb_regfile;

    localparam logic [31:0] RR = 32'hA5A5_0000;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        WBWrite;
    logic [4:0]  WBAddr;
    logic [31:0] WBData;
    logic [4:0]  ReadAddrA;
    logic [4:0]  ReadAddrB;
    logic        UseA;
    logic        UseB;
    logic        IssueValid;
    logic [4:0]  IssueDest;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        Stall;
    logic        ScoreErr;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(.REG_RESET(RR)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .WBWrite    (WBWrite),
        .WBAddr     (WBAddr),
        .WBData     (WBData),
        .ReadAddrA  (ReadAddrA),
        .ReadAddrB  (ReadAddrB),
        .UseA       (UseA),
        .UseB       (UseB),
        .IssueValid (IssueValid),
        .IssueDest  (IssueDest),
        .DataA      (DataA),
        .DataB      (DataB),
        .Stall      (Stall),
        .ScoreErr   (ScoreErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ua;
        logic        ub;
        logic        iv;
        logic [4:0]  id;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: register contents, outstanding-write counts, sticky error.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic ua, input logic ub, input logic iv, input logic [4:0] id,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic es, input logic ee);
        vec_t v;
        v.wbw = wbw; v.wba = wba; v.wbd = wbd; v.ra = ra; v.rb = rb;
        v.ua = ua; v.ub = ub; v.iv = iv; v.id = id;
        v.ea = ea; v.eb = eb; v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        WBWrite = v.wbw; WBAddr = v.wba; WBData = v.wbd;
        ReadAddrA = v.ra; ReadAddrB = v.rb; UseA = v.ua; UseB = v.ub;
        IssueValid = v.iv; IssueDest = v.id;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = (i == 0) ? 32'd0 : RR;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    // Operand value as seen this cycle: a fresh write-back wins over stored contents.
    function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (v.wbw && v.wba == a) return v.wbd;
        return m_reg[a];
    endfunction

    // Writes still outstanding for an operand once this cycle's write-back is credited.
    function automatic int m_pending(input vec_t v, input logic [4:0] a);
        int p;
        p = m_cnt[a];
        if (a != 0 && v.wbw && v.wba == a) p = p - 1;
        return p;
    endfunction

    function automatic logic m_stall(input vec_t v);
        logic s;
        s = 1'b0;
        if (v.ua && m_pending(v, v.ra) > 0) s = 1'b1;
        if (v.ub && m_pending(v, v.rb) > 0) s = 1'b1;
        if (v.id != 0 && m_cnt[v.id] >= 3) s = 1'b1;
        return s;
    endfunction

    task automatic model_step(input vec_t v);
        logic s;
        s = m_stall(v);
        if (v.iv && !s && v.id != 0) m_cnt[v.id] = m_cnt[v.id] + 1;
        if (v.wbw && v.wba != 0) begin
            m_reg[v.wba] = v.wbd;
            m_cnt[v.wba] = m_cnt[v.wba] - 1;
            if (m_cnt[v.wba] < 0) begin
                m_cnt[v.wba] = 0;
                m_err = 1'b1;
            end
        end
    endtask

    initial begin
        vec_t v;

        nReset = 1'b0;
        v = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(posedge Clock);
        #1;
        check("reset DataA r1", DataA, RR);
        check("reset DataB r0", DataB, 32'd0);
        check("reset Stall", {31'd0, Stall}, 32'd0);
        check("reset ScoreErr", {31'd0, ScoreErr}, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        // Directed vectors: each entry is one cycle, outputs checked before the next edge.
        vecs.push_back(mk(0, 0, 0,            5, 0, 0, 0, 1, 5, RR,           0,            0, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 5, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0));
        vecs.push_back(mk(1, 0, 32'h1234,     5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 5, 0, 0, 0, 0, 0,            32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 7, 0,            0,            0, 0));
        vecs.push_back(mk(1, 7, 32'h1,        7, 0, 0, 0, 0, 0, 32'h1,        0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 7, 0, 0, 1, 7, 0,            32'h1,        0, 0));
        vecs.push_back(mk(1, 7, 32'h55,       0, 7, 0, 1, 0, 0, 0,            32'h55,       0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 7, 0, 0, 0, 0, 0,            32'h55,       0, 0));
        vecs.push_back(mk(0, 0, 0,            3, 0, 0, 0, 1, 3, RR,           0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            3, 0, 1, 0, 1, 0, RR,           0,            1, 0));
        vecs.push_back(mk(0, 0, 0,            3, 0, 1, 0, 1, 3, RR,           0,            1, 0));
        vecs.push_back(mk(1, 3, 32'hCAFE0003, 3, 0, 1, 0, 0, 0, 32'hCAFE0003, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            3, 0, 1, 0, 0, 0, 32'hCAFE0003, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            1, 0));
        vecs.push_back(mk(1, 9, 32'h99,       0, 0, 0, 0, 0, 0, 0,            0,            0, 0));
        vecs.push_back(mk(1, 9, 32'h98,       0, 0, 0, 0, 1, 9, 0,            0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 9, 0,            0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 9, 0, 0, 1, 9, 0,            32'h98,       1, 0));
        vecs.push_back(mk(1, 9, 32'h77,       0, 9, 0, 1, 0, 0, 0,            32'h77,       1, 0));
        vecs.push_back(mk(1, 9, 32'h78,       0, 9, 0, 1, 0, 0, 0,            32'h78,       1, 0));
        vecs.push_back(mk(1, 9, 32'h79,       0, 9, 0, 1, 0, 0, 0,            32'h79,       0, 0));
        vecs.push_back(mk(1, 4, 32'h44444444, 4, 0, 0, 0, 0, 0, 32'h44444444, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            4, 0, 0, 0, 0, 0, 32'h44444444, 0,            0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 9, 0, 0, 0, 0, 0,            32'h79,       0, 1));
        vecs.push_back(mk(0, 0, 0,            4, 0, 1, 0, 1, 4, 32'h44444444, 0,            0, 1));
        vecs.push_back(mk(0, 0, 0,            4, 0, 1, 0, 0, 0, 32'h44444444, 0,            1, 1));

        foreach (vecs[i]) begin
            @(negedge Clock);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d DataA", i), DataA, vecs[i].ea);
            check($sformatf("vec%0d DataB", i), DataB, vecs[i].eb);
            check($sformatf("vec%0d Stall", i), {31'd0, Stall}, {31'd0, vecs[i].es});
            check($sformatf("vec%0d ScoreErr", i), {31'd0, ScoreErr}, {31'd0, vecs[i].ee});
        end

        // Asynchronous reset in the middle of a cycle; write and issue during reset are dropped.
        @(negedge Clock);
        drive(mk(0, 0, 0, 4, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre-reset Stall", {31'd0, Stall}, 32'd1);
        check("pre-reset ScoreErr", {31'd0, ScoreErr}, 32'd1);
        #1;
        nReset = 1'b0;
        #1;
        check("async reset ScoreErr", {31'd0, ScoreErr}, 32'd0);
        check("async reset Stall", {31'd0, Stall}, 32'd0);
        check("async reset DataA r4", DataA, RR);
        check("async reset DataB r9", DataB, RR);
        drive(mk(1, 4, 32'h0BAD0BAD, 4, 6, 1, 0, 1, 6, 0, 0, 0, 0));
        @(posedge Clock);
        @(negedge Clock);
        drive(mk(0, 0, 0, 4, 6, 0, 1, 0, 0, 0, 0, 0, 0));
        nReset = 1'b1;
        #1;
        check("post-reset DataA r4", DataA, RR);
        check("post-reset Stall r6", {31'd0, Stall}, 32'd0);
        check("post-reset ScoreErr", {31'd0, ScoreErr}, 32'd0);

        // Randomized traffic on a small register window to provoke hazards and saturation.
        model_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge Clock);
            v.wba = 5'($urandom_range(0, 7));
            if (m_cnt[v.wba] > 0) v.wbw = 1'($urandom_range(0, 1));
            else                  v.wbw = ($urandom_range(0, 15) == 0);
            v.wbd = $urandom;
            v.ra  = 5'($urandom_range(0, 7));
            v.rb  = 5'($urandom_range(0, 7));
            v.ua  = 1'($urandom_range(0, 1));
            v.ub  = 1'($urandom_range(0, 1));
            v.iv  = 1'($urandom_range(0, 1));
            v.id  = 5'($urandom_range(0, 7));
            drive(v);
            #1;
            check($sformatf("rand%0d DataA", n), DataA, m_read(v, v.ra));
            check($sformatf("rand%0d DataB", n), DataB, m_read(v, v.rb));
            check($sformatf("rand%0d Stall", n), {31'd0, Stall}, {31'd0, m_stall(v)});
            check($sformatf("rand%0d ScoreErr", n), {31'd0, ScoreErr}, {31'd0, m_err});
            model_step(v);
        end

        @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
